// File: rtl/cdce_cfg_pkg.sv
// Purpose: shared state encoding, bus widths and default register table for the CDCE config path.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: cfg_state_t (sequencer FSM), CDCE_WORD_W / CDCE_ADDR_W, CDCE_REG_0..8 words,
//           cnt_width() helper for sizing the saturating counters.
package cdce_cfg_pkg;

   localparam int CDCE_WORD_W = 32;
   localparam int CDCE_ADDR_W = 4;

   typedef enum logic [2:0] {
      ST_PWR_WAIT  = 3'd0,
      ST_IDLE      = 3'd1,
      ST_LOAD      = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5,
      ST_FIN       = 3'd6,
      ST_ERR       = 3'd7
   } cfg_state_t;

   // Default CDCE register words; the low nibble carries the target register address.
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_0 = 32'hEB84_0320;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_1 = 32'hEB84_0301;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_2 = 32'hEB84_0302;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_3 = 32'hEB84_0303;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_4 = 32'hEB14_0314;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_5 = 32'h101C_0BE5;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_6 = 32'h04BE_19A6;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_7 = 32'hBD00_7FD7;
   localparam logic [CDCE_WORD_W-1:0] CDCE_REG_8 = 32'h8000_1808;

   // Counter width for a terminal count of 'terminal' cycles; never narrower than 1 bit.
   function automatic int cnt_width(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/cdce_reg_rom.sv
// Purpose: register-word table for the CDCE configuration pass (word_addr -> word_data).
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the address every cycle.
// Ports: word_addr (in, table index), word_data (out, 32-bit word; 0 for addr >= NUM_WORDS).
module cdce_reg_rom
   import cdce_cfg_pkg::*;
#(
   parameter int NUM_WORDS = 9
)(
   input  logic [CDCE_ADDR_W-1:0] word_addr,
   output logic [CDCE_WORD_W-1:0] word_data
);

   logic [CDCE_WORD_W-1:0] table_word;

   always_comb begin
      table_word = '0;
      case (word_addr)
         4'd0:    table_word = CDCE_REG_0;
         4'd1:    table_word = CDCE_REG_1;
         4'd2:    table_word = CDCE_REG_2;
         4'd3:    table_word = CDCE_REG_3;
         4'd4:    table_word = CDCE_REG_4;
         4'd5:    table_word = CDCE_REG_5;
         4'd6:    table_word = CDCE_REG_6;
         4'd7:    table_word = CDCE_REG_7;
         4'd8:    table_word = CDCE_REG_8;
         default: table_word = '0;
      endcase
   end

   // Entries beyond the configured pass length read as zero so a shorter table
   // never leaks default words.
   assign word_data = (int'(word_addr) < NUM_WORDS) ? table_word : '0;

endmodule

// File: rtl/cdce_config_sequencer.sv
// Purpose: walks the CDCE register table and hands each word to the serial shifter.
// Latency: first start_transaction POWERUP_CYCLES+1 edges after reset release (AUTO_START=1).
// Backpressure: holds start_transaction until the shifter drops transaction_done; per-word timeout.
// Ports: clk/reset_n; start_config (pass request pulse); word_addr/word_data (table lookup);
//        parallel_word/start_transaction/transaction_done (shifter handshake);
//        config_busy/config_done/config_error (status to board controller).
module cdce_config_sequencer
   import cdce_cfg_pkg::*;
#(
   parameter int NUM_WORDS      = 9,
   parameter int POWERUP_CYCLES = 1024,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int AUTO_START     = 1
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start_config,
   output logic [CDCE_ADDR_W-1:0] word_addr,
   input  logic [CDCE_WORD_W-1:0] word_data,
   output logic [CDCE_WORD_W-1:0] parallel_word,
   output logic                   start_transaction,
   input  logic                   transaction_done,
   output logic                   config_busy,
   output logic                   config_done,
   output logic                   config_error
);

   localparam int PWR_W = cnt_width(POWERUP_CYCLES);
   localparam int GAP_W = cnt_width(GAP_CYCLES);
   localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);

   localparam logic [PWR_W-1:0]       PWR_TC    = PWR_W'(POWERUP_CYCLES - 1);
   localparam logic [GAP_W-1:0]       GAP_TC    = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]        TO_TC     = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CDCE_ADDR_W-1:0] LAST_ADDR = CDCE_ADDR_W'(NUM_WORDS - 1);
   localparam logic                   AUTO      = (AUTO_START != 0);

   cfg_state_t             state_q, state_d;
   logic [PWR_W-1:0]       pwr_cnt_q, pwr_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic [TO_W-1:0]        to_cnt_inc;
   logic [CDCE_ADDR_W-1:0] word_addr_q, word_addr_d;
   logic [CDCE_WORD_W-1:0] parallel_word_q, parallel_word_d;
   logic                   start_q, start_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;

   // One timeout count spans ISSUE and WAIT_DONE; it saturates rather than wraps.
   assign to_cnt_inc = (to_cnt_q == TO_TC) ? to_cnt_q : to_cnt_q + TO_W'(1);

   always_comb begin
      state_d         = state_q;
      pwr_cnt_d       = pwr_cnt_q;
      gap_cnt_d       = '0;
      to_cnt_d        = to_cnt_q;
      word_addr_d     = word_addr_q;
      parallel_word_d = parallel_word_q;
      done_d          = done_q;
      error_d         = error_q;

      case (state_q)
         ST_PWR_WAIT: begin
            // start_config is deliberately not looked at: the wait cannot be shortened.
            if (pwr_cnt_q == PWR_TC) begin
               state_d = AUTO ? ST_LOAD : ST_IDLE;
            end else begin
               pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
            end
         end
         ST_IDLE: begin
            if (start_config) begin
               state_d     = ST_LOAD;
               word_addr_d = '0;
               done_d      = 1'b0;
               error_d     = 1'b0;
            end
         end
         ST_LOAD: begin
            // parallel_word is only written here, so it stays frozen for the whole
            // transfer; the shifter samples it one cycle after seeing start.
            parallel_word_d = word_data;
            to_cnt_d        = '0;
            state_d         = ST_ISSUE;
         end
         ST_ISSUE: begin
            to_cnt_d = to_cnt_inc;
            if (!transaction_done) begin
               state_d = ST_WAIT_DONE;
            end else if (to_cnt_q == TO_TC) begin
               // A disabled shifter never drops done; give up on this pass.
               state_d = ST_ERR;
            end
         end
         ST_WAIT_DONE: begin
            to_cnt_d = to_cnt_inc;
            if (transaction_done) begin
               state_d = ST_GAP;
            end else if (to_cnt_q == TO_TC) begin
               state_d = ST_ERR;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_TC) begin
               if (word_addr_q == LAST_ADDR) begin
                  state_d = ST_FIN;
               end else begin
                  word_addr_d = word_addr_q + CDCE_ADDR_W'(1);
                  state_d     = ST_LOAD;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         ST_FIN: begin
            // Any start_config seen this cycle is dropped; it must be re-issued from IDLE.
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            error_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered outputs are derived from the next state so they line up with it.
      start_d = (state_d == ST_ISSUE);
      busy_d  = ((state_d == ST_PWR_WAIT) && AUTO) ||
                (state_d == ST_LOAD) || (state_d == ST_ISSUE) ||
                (state_d == ST_WAIT_DONE) || (state_d == ST_GAP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_PWR_WAIT;
         pwr_cnt_q       <= '0;
         gap_cnt_q       <= '0;
         to_cnt_q        <= '0;
         word_addr_q     <= '0;
         parallel_word_q <= '0;
         start_q         <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         pwr_cnt_q       <= pwr_cnt_d;
         gap_cnt_q       <= gap_cnt_d;
         to_cnt_q        <= to_cnt_d;
         word_addr_q     <= word_addr_d;
         parallel_word_q <= parallel_word_d;
         start_q         <= start_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign word_addr         = word_addr_q;
   assign parallel_word     = parallel_word_q;
   assign start_transaction = start_q;
   assign config_busy       = busy_q;
   assign config_done       = done_q;
   assign config_error      = error_q;

endmodule
